// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants and S-box generator state encoding
package aes_pkg;

    localparam logic [7:0] AES_SBOX_AFFINE_C  = 8'h63;
    localparam logic [7:0] AES_GF_POLY_RED    = 8'h1B;
    localparam logic [7:0] AES_GF_INV3_RED    = 8'h09;
    localparam int         AES_SBOX_GEN_STEPS = 255;
    localparam int         AES_TBL_AW         = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ZERO  = 2'd1,
        GEN   = 2'd2,
        VALID = 2'd3
    } sbox_gen_state_t;

endpackage

// File: rtl/sbox_table_gen_if.sv
// rtl/sbox_table_gen_if.sv - control handshake and dual table write port bundle
interface sbox_table_gen_if;
    import aes_pkg::*;

    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  table_valid;
    logic                  a_we;
    logic [AES_TBL_AW-1:0] a_waddr;
    logic [7:0]            a_wdata;
    logic                  b_we;
    logic [AES_TBL_AW-1:0] b_waddr;
    logic [7:0]            b_wdata;

    modport master (
        input  start,
        output busy, done, table_valid,
        output a_we, a_waddr, a_wdata,
        output b_we, b_waddr, b_wdata
    );

    modport slave (
        output start,
        input  busy, done, table_valid,
        input  a_we, a_waddr, a_wdata,
        input  b_we, b_waddr, b_wdata
    );

endinterface

// File: rtl/sbox_gen_step.sv
// rtl/sbox_gen_step.sv - one generator step: p*3, q/3 in GF(2^8) and the affine S-box output of q
module sbox_gen_step
    import aes_pkg::*;
(
    input  logic [7:0] p,
    input  logic [7:0] q,
    output logic [7:0] p_next,
    output logic [7:0] q_next,
    output logic [7:0] s
);

    logic [7:0] q_x1;
    logic [7:0] q_x2;
    logic [7:0] q_x4;

    assign p_next = p ^ {p[6:0], 1'b0} ^ (p[7] ? AES_GF_POLY_RED : 8'h00);

    // q stays the multiplicative inverse of p, so s is S(p_next)
    assign q_x1   = q ^ {q[6:0], 1'b0};
    assign q_x2   = q_x1 ^ {q_x1[5:0], 2'b00};
    assign q_x4   = q_x2 ^ {q_x2[3:0], 4'b0000};
    assign q_next = q_x4 ^ (q_x4[7] ? AES_GF_INV3_RED : 8'h00);

    assign s = q_next
             ^ {q_next[6:0], q_next[7]}
             ^ {q_next[5:0], q_next[7:6]}
             ^ {q_next[4:0], q_next[7:5]}
             ^ {q_next[3:0], q_next[7:4]}
             ^ AES_SBOX_AFFINE_C;

endmodule

// File: rtl/sbox_table_gen.sv
// rtl/sbox_table_gen.sv - S-box table generator FSM; define SBOX_GEN_INV_EN to also write inverse entries
module sbox_table_gen
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    sbox_table_gen_if.master tbl
);

    sbox_gen_state_t state_q;
    sbox_gen_state_t state_d;

    logic [7:0] p_q, q_q;
    logic [7:0] p_nx, q_nx, s_nx;
    logic       load_init;
    logic       step_en;
    logic       finish;
    logic       wr_en;
    logic [7:0] fwd_addr_d;
    logic [7:0] fwd_data_d;

    logic                  a_we_q;
    logic [AES_TBL_AW-1:0] a_waddr_q;
    logic [7:0]            a_wdata_q;
    logic                  done_q;
    logic                  valid_q;

    sbox_gen_step u_step (
        .p      (p_q),
        .q      (q_q),
        .p_next (p_nx),
        .q_next (q_nx),
        .s      (s_nx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // p_q holds the entry on the write port; p == 1 in GEN marks the last step
    always_comb begin
        state_d   = state_q;
        load_init = 1'b0;
        step_en   = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE, VALID: begin
                if (tbl.start) begin
                    state_d   = ZERO;
                    load_init = 1'b1;
                end
            end
            ZERO: begin
                state_d = GEN;
                step_en = 1'b1;
            end
            GEN: begin
                if (p_q == 8'h01) begin
                    state_d = VALID;
                    finish  = 1'b1;
                end else begin
                    step_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        wr_en      = load_init | step_en;
        fwd_addr_d = load_init ? 8'h00 : p_nx;
        fwd_data_d = load_init ? AES_SBOX_AFFINE_C : s_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q       <= 8'h01;
            q_q       <= 8'h01;
            a_we_q    <= 1'b0;
            a_waddr_q <= '0;
            a_wdata_q <= '0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            if (load_init) begin
                p_q <= 8'h01;
                q_q <= 8'h01;
            end else if (step_en) begin
                p_q <= p_nx;
                q_q <= q_nx;
            end
            a_we_q    <= wr_en;
            a_waddr_q <= wr_en ? {1'b0, fwd_addr_d} : '0;
            a_wdata_q <= wr_en ? fwd_data_d : 8'h00;
            done_q    <= finish;
            if (load_init) begin
                valid_q <= 1'b0;
            end else if (finish) begin
                valid_q <= 1'b1;
            end
        end
    end

    assign tbl.busy        = (state_q == ZERO) || (state_q == GEN);
    assign tbl.done        = done_q;
    assign tbl.table_valid = valid_q;
    assign tbl.a_we        = a_we_q;
    assign tbl.a_waddr     = a_waddr_q;
    assign tbl.a_wdata     = a_wdata_q;

`ifdef SBOX_GEN_INV_EN
    logic                  b_we_q;
    logic [AES_TBL_AW-1:0] b_waddr_q;
    logic [7:0]            b_wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_we_q    <= 1'b0;
            b_waddr_q <= '0;
            b_wdata_q <= '0;
        end else begin
            b_we_q    <= wr_en;
            b_waddr_q <= wr_en ? {1'b1, fwd_data_d} : '0;
            b_wdata_q <= wr_en ? fwd_addr_d : 8'h00;
        end
    end

    assign tbl.b_we    = b_we_q;
    assign tbl.b_waddr = b_waddr_q;
    assign tbl.b_wdata = b_wdata_q;
`else
    assign tbl.b_we    = 1'b0;
    assign tbl.b_waddr = '0;
    assign tbl.b_wdata = 8'h00;
`endif

endmodule

// File: tb/tb_sbox_table_gen.sv
// tb/tb_sbox_table_gen.sv - directed bench for sbox_table_gen, forward half always, inverse half with SBOX_GEN_INV_EN
module tb_sbox_table_gen;

    logic clk;
    logic rst_n;

    sbox_table_gen_if tbl ();

    sbox_table_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tbl   (tbl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem  [512];
    int         wcnt [512];
    int         a_writes;
    int         b_writes;
    logic [8:0] w1_addr, w2_addr, wl_addr;
    logic [7:0] w1_data, w2_data, wl_data;
    logic [8:0] w1_baddr;
    logic [7:0] w1_bdata;

    logic [7:0] fips [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic record_writes(input int cyc);
        if (tbl.a_we === 1'b1) begin
            mem[tbl.a_waddr] = tbl.a_wdata;
            wcnt[tbl.a_waddr]++;
            a_writes++;
        end
        if (tbl.b_we === 1'b1) begin
            mem[tbl.b_waddr] = tbl.b_wdata;
            wcnt[tbl.b_waddr]++;
            b_writes++;
        end
        if (cyc == 1) begin
            w1_addr = tbl.a_waddr;  w1_data = tbl.a_wdata;
            w1_baddr = tbl.b_waddr; w1_bdata = tbl.b_wdata;
        end
        if (cyc == 2)   begin w2_addr = tbl.a_waddr; w2_data = tbl.a_wdata; end
        if (cyc == 256) begin wl_addr = tbl.a_waddr; wl_data = tbl.a_wdata; end
    endtask

    // start pulse in cycle 0; optional stray start driven in cycle 'stray'
    task automatic run_gen(input string tag, input int stray, output int done_cyc);
        int busy_err;
        int tv_err;
        busy_err = 0;
        tv_err   = 0;
        done_cyc = -1;
        a_writes = 0;
        b_writes = 0;
        for (int i = 0; i < 512; i++) begin
            mem[i]  = 8'h00;
            wcnt[i] = 0;
        end
        @(negedge clk);
        tbl.start = 1'b1;
        @(negedge clk);
        tbl.start = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (cyc > 1) @(negedge clk);
            record_writes(cyc);
            if (tbl.busy !== (cyc <= 256)) busy_err++;
            if (tbl.done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (tbl.table_valid !== 1'b0) tv_err++;
            tbl.start = (cyc == stray);
        end
        tbl.start = 1'b0;
        check({tag, "_done_cycle"}, done_cyc, 257);
        check({tag, "_busy_window"}, busy_err, 0);
        check({tag, "_valid_low_during_run"}, tv_err, 0);
        check({tag, "_valid_at_done"}, tbl.table_valid, 1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, tbl.done, 0);
        check({tag, "_valid_held"}, tbl.table_valid, 1);
    endtask

    task automatic verify_table(input string tag);
        int fwd_err;
        int once_err;
        int inv_err;
        fwd_err  = 0;
        once_err = 0;
        inv_err  = 0;
        for (int x = 0; x < 256; x++) begin
            if (mem[x] !== fips[x]) fwd_err++;
            if (wcnt[x] != 1) once_err++;
`ifdef SBOX_GEN_INV_EN
            if (wcnt[256 + int'(fips[x])] != 1) once_err++;
            if (mem[256 + int'(fips[x])] !== 8'(x)) inv_err++;
`endif
        end
        check({tag, "_fwd_entries"}, fwd_err, 0);
        check({tag, "_written_once"}, once_err, 0);
        check({tag, "_inverse_entries"}, inv_err, 0);
        check({tag, "_a_writes"}, a_writes, 256);
`ifdef SBOX_GEN_INV_EN
        check({tag, "_b_writes"}, b_writes, 256);
`else
        check({tag, "_b_never_written"}, b_writes, 0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        tbl.start = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", tbl.busy, 0);
        check("reset_done", tbl.done, 0);
        check("reset_table_valid", tbl.table_valid, 0);
        check("reset_port_a", {tbl.a_we, tbl.a_waddr, tbl.a_wdata}, 0);
        check("reset_port_b", {tbl.b_we, tbl.b_waddr, tbl.b_wdata}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_gen("run1", 0, dc);
        check("zero_write_addr", w1_addr, 9'h000);
        check("zero_write_data", w1_data, 8'h63);
        check("first_gen_addr", w2_addr, 9'h003);
        check("first_gen_data", w2_data, 8'h7b);
        check("last_gen_addr", wl_addr, 9'h001);
        check("last_gen_data", wl_data, 8'h7c);
        check("mem_000", mem[9'h000], 8'h63);
        check("mem_001", mem[9'h001], 8'h7c);
        check("mem_053", mem[9'h053], 8'hed);
`ifdef SBOX_GEN_INV_EN
        check("zero_write_b_addr", w1_baddr, 9'h163);
        check("zero_write_b_data", w1_bdata, 8'h00);
        check("mem_1ed", mem[9'h1ed], 8'h53);
        check("mem_116", mem[9'h116], 8'hff);
        check("mem_163", mem[9'h163], 8'h00);
`else
        check("tied_b_addr", w1_baddr, 9'h000);
        check("tied_b_data", w1_bdata, 8'h00);
`endif
        verify_table("run1");

        run_gen("stray_start", 100, dc);
        verify_table("stray_start");

        @(negedge clk);
        tbl.start = 1'b1;
        @(negedge clk);
        tbl.start = 1'b0;
        repeat (49) @(negedge clk);
        check("abort_pre_we", tbl.a_we, 1);
        check("abort_pre_busy", tbl.busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_a_we", tbl.a_we, 0);
        check("abort_b_we", tbl.b_we, 0);
        check("abort_busy", tbl.busy, 0);
        check("abort_table_valid", tbl.table_valid, 0);
        check("abort_addr_data", {tbl.a_waddr, tbl.a_wdata, tbl.b_waddr, tbl.b_wdata}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_abort_valid", tbl.table_valid, 0);

        run_gen("after_abort", 0, dc);
        verify_table("after_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sbox_table_gen.md
# sbox_table_gen

Generator that fills the byte-substitution table memory read by the AES datapath's S-box lookup. After a `start` request it computes all 256 forward S-box entries and, optionally, all 256 inverse entries. It writes them through a dual write port into a 512-entry table. Address bit 8 selects the inverse half, which matches the `{inv_flag, byte}` read addressing. It replaces a fixed ROM image and produces the table at run time; it can also rebuild the table after a soft fault.

## Interface
- No parameters; widths fixed by AES (8-bit bytes, 9-bit table address).
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: generation request; sampled only in IDLE/VALID.
- `busy` output 1: high while table writes are in progress.
- `done` output 1: one-cycle pulse in the cycle after the last write.
- `table_valid` output 1: level; table complete, cleared by `start` or reset.
- `a_we` output 1: write enable, forward-entry port.
- `a_waddr` output 9: `{1'b0, x}`.
- `a_wdata` output 8: S(x).
- `b_we` output 1: write enable, inverse-entry port.
- `b_waddr` output 9: `{1'b1, S(x)}`.
- `b_wdata` output 8: x.

## Operation
- FSM states: IDLE, ZERO, GEN, VALID.
- IDLE/VALID with `start`=1 → ZERO. `table_valid` clears in the same edge.
- ZERO writes the non-invertible entry: a = {0,0x00}←0x63, b = {1,0x63}←0x00. It loads p=q=0x01 and moves to GEN.
- GEN runs one step per cycle:
  - p ← p ^ (p<<1) ^ (p[7] ? 0x1B : 0), which is p·3 in GF(2^8).
  - q ← q/3: q ^= q<<1; q ^= q<<2; q ^= q<<4; then if q[7], q ^= 0x09.
  - s = q ^ rotl(q,1) ^ rotl(q,2) ^ rotl(q,3) ^ rotl(q,4) ^ 0x63.
  - Writes a = {0,p}←s and b = {1,s}←p, using the updated p and q.
- GEN exits after the step whose new p equals 0x01 (255 steps), then goes to VALID.
- All arithmetic is 8-bit with shifted-out bits discarded; no carries.
- Both ports write in the same cycle. Addresses never collide because bit 8 differs.
- `start` while `busy` is ignored; it is not queued.
- Reset values: state IDLE. All outputs 0, including addresses and data. p and q are 0x01.
- `rst_n` low mid-generation aborts immediately. Write enables drop asynchronously and the partial table is left as-is. `table_valid`=0 until a new full run completes.

## Timing
- Write-port outputs are registered.
- Cycle 0: `start` sampled.
- Cycle 1: ZERO write visible; `busy`=1.
- Cycles 2..256: 255 GEN writes. Cycle 2 writes p=0x03, s=0x7B. Cycle 256 writes p=0x01, s=0x7C.
- Cycle 257: `busy`=0, writes idle, `done`=1 for one cycle, `table_valid`=1 and held.
- Total latency from `start` to `done` is 257 cycles. `start` in cycle 257 or later restarts the run.
- The consumer must not read the table while `table_valid`=0.

## Configuration
- `SBOX_GEN_INV_EN` defined:
  - Inverse entries are written on port b as above.
- `SBOX_GEN_INV_EN` undefined:
  - Port b is tied off: `b_we`=0, `b_waddr`=0, `b_wdata`=0.
  - Only the forward half is written; timing is unchanged.
  - The inverse-half contents are undefined and the inverse cipher is unsupported.

## Structure
- Shared package `aes_pkg` holds:
  - `AES_SBOX_AFFINE_C` = 8'h63.
  - `AES_GF_POLY_RED` = 8'h1B.
  - `AES_GF_INV3_RED` = 8'h09.
  - `AES_SBOX_GEN_STEPS` = 255.
  - `AES_TBL_AW` = 9.
  - The FSM state enum.
- One combinational sub-module, `sbox_gen_step`: takes (p, q) and returns (p_next, q_next, s). It is reusable by a software-model check.
- The top block holds the FSM, the p/q registers and the output registers.

## Test plan
- Reset then `start` pulse: `done` appears at exactly cycle 257. `busy` is high in cycles 1..256. 512 writes in total when `SBOX_GEN_INV_EN` is defined.
- Capture writes into a model memory, then check: {0,0x00}=0x63, {0,0x01}=0x7C, {0,0x53}=0xED, {1,0xED}=0x53, {1,0x16}=0xFF, {1,0x63}=0x00.
- Full check: every forward entry matches the FIPS-197 table, each address is written exactly once, and inv[S(x)]=x for all x.
- Pulse `start` at cycle 100 mid-run: it is ignored, and `done` still arrives at cycle 257.
- Assert `rst_n` low at cycle 50: all outputs go to 0 immediately and `table_valid`=0. A fresh `start` then completes normally.
- Build without `SBOX_GEN_INV_EN`: `b_we` is never high, forward entries are all correct, and `done` still arrives at cycle 257.
